// File: rtl/rv_alu_if.sv
// Operand/result bundle between the execute-stage control and the RV32I ALU.
interface rv_alu_if;
  logic [31:0] oprand_a;
  logic [31:0] oprand_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_data;
  logic [31:0] alu_data_q;

  // Driver side: supplies operands and the operation, observes the results.
  modport master (
    output oprand_a,
    output oprand_b,
    output alu_sel,
    input  alu_data,
    input  alu_data_q
  );

  // ALU side: consumes operands, produces combinational and registered results.
  modport slave (
    input  oprand_a,
    input  oprand_b,
    input  alu_sel,
    output alu_data,
    output alu_data_q
  );
endinterface

// File: rtl/rv_alu.sv
// RV32I integer ALU. alu_data is purely combinational so forwarding and
// branch resolution can use it in the same cycle; alu_data_q is the copy
// that crosses into the EX/MEM pipeline register.
module rv_alu (
  input  logic     clk,
  input  logic     rst,
  rv_alu_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [32:0] diff;
  logic        lt_unsigned;
  logic        lt_signed;
  logic [31:0] alu_data_d;
  logic [31:0] alu_data_q;

  assign op_a  = bus.oprand_a;
  assign op_b  = bus.oprand_b;
  // Only the low five bits of B are a legal shift amount in RV32I.
  assign shamt = op_b[4:0];

  // One 33-bit subtractor serves SUB, SLT and SLTU. The extra MSB is the
  // borrow out, which is exactly the unsigned less-than result.
  assign diff        = {1'b0, op_a} - {1'b0, op_b};
  assign lt_unsigned = diff[32];
  // With differing signs the negative operand is the smaller one; with equal
  // signs the difference cannot overflow, so its sign bit is the answer.
  assign lt_signed   = (op_a[31] != op_b[31]) ? op_a[31] : diff[31];

  // Result mux; unused encodings return zero rather than X.
  always_comb begin
    alu_data_d = 32'd0;
    case (bus.alu_sel)
      OP_ADD:  alu_data_d = op_a + op_b;
      OP_SUB:  alu_data_d = diff[31:0];
      OP_SLT:  alu_data_d = {31'd0, lt_signed};
      OP_SLTU: alu_data_d = {31'd0, lt_unsigned};
      OP_XOR:  alu_data_d = op_a ^ op_b;
      OP_OR:   alu_data_d = op_a | op_b;
      OP_AND:  alu_data_d = op_a & op_b;
      OP_SLL:  alu_data_d = op_a << shamt;
      OP_SRL:  alu_data_d = op_a >> shamt;
      OP_SRA:  alu_data_d = $unsigned($signed(op_a) >>> shamt);
      OP_LUI:  alu_data_d = op_b;
      default: alu_data_d = 32'd0;
    endcase
  end

  // Pipeline copy of the result; no enable, stalls are handled upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data_q <= 32'd0;
    end else begin
      alu_data_q <= alu_data_d;
    end
  end

  assign bus.alu_data   = alu_data_d;
  assign bus.alu_data_q = alu_data_q;

endmodule

// File: tb/tb_rv_alu.sv
// Bench for rv_alu: each applied vector pushes its expected combinational
// result (due this cycle) and registered result (due next cycle) into a
// scoreboard queue; a monitor on the falling edge pops and compares.
module tb_rv_alu;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   stim_done;

  rv_alu_if bus ();

  rv_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          due;
    bit          is_reg;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, written from the instruction definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] sel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    case (sel)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd5:  r = a | b;
      4'd6:  r = a & b;
      4'd7:  r = a << sh;
      4'd8:  r = a >> sh;
      4'd9:  r = $unsigned($signed(a) >>> sh);
      4'd10: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Apply one vector for one cycle and enqueue both expectations.
  task automatic apply(input string name, input logic r, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    bus.alu_sel  = sel;
    bus.oprand_a = a;
    bus.oprand_b = b;
    e.name = name; e.exp = exp; e.due = cyc; e.is_reg = 1'b0;
    sb.push_back(e);
    e.name = {name, "_q"}; e.exp = r ? 32'd0 : exp; e.due = cyc + 1; e.is_reg = 1'b1;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation that has become due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = e.is_reg ? bus.alu_data_q : bus.alu_data;
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    cyc = 0; n_checks = 0; n_fail = 0; stim_done = 1'b0;
    rst = 1'b1;
    bus.alu_sel = 4'd0; bus.oprand_a = 32'd0; bus.oprand_b = 32'd0;

    // Reset and register path
    apply("rst0",     1'b1, 4'd0, 32'd0, 32'd0, 32'd0);
    apply("rst1",     1'b1, 4'd0, 32'd0, 32'd0, 32'd0);
    apply("add3_4",   1'b0, 4'd0, 32'd3, 32'd4, 32'd7);
    apply("add_rst",  1'b1, 4'd0, 32'd3, 32'd4, 32'd7);

    // Arithmetic wrap
    apply("add_wrap", 1'b0, 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
    apply("sub_wrap", 1'b0, 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF);

    // Signed vs unsigned compare
    apply("slt_neg",  1'b0, 4'd2, 32'h8000_0000, 32'h1, 32'd1);
    apply("sltu_neg", 1'b0, 4'd3, 32'h8000_0000, 32'h1, 32'd0);
    apply("slt_m1",   1'b0, 4'd2, 32'h1, 32'hFFFF_FFFF, 32'd0);
    apply("sltu_m1",  1'b0, 4'd3, 32'h1, 32'hFFFF_FFFF, 32'd1);
    apply("slt_eq",   1'b0, 4'd2, 32'h1234_5678, 32'h1234_5678, 32'd0);
    apply("sltu_eq",  1'b0, 4'd3, 32'h1234_5678, 32'h1234_5678, 32'd0);

    // Logic
    apply("xor",      1'b0, 4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
    apply("or",       1'b0, 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
    apply("and",      1'b0, 4'd6, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);

    // Shifts; upper bits of B must be ignored
    apply("sll4",     1'b0, 4'd7, 32'h8000_0001, 32'hFFFF_FFE4, 32'h0000_0010);
    apply("srl4",     1'b0, 4'd8, 32'h8000_0001, 32'hFFFF_FFE4, 32'h0800_0000);
    apply("sra4",     1'b0, 4'd9, 32'h8000_0001, 32'hFFFF_FFE4, 32'hF800_0000);
    apply("sll0",     1'b0, 4'd7, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
    apply("srl0",     1'b0, 4'd8, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
    apply("sra0",     1'b0, 4'd9, 32'h8000_0001, 32'hFFFF_FFE0, 32'h8000_0001);
    apply("sra31",    1'b0, 4'd9, 32'h8000_0001, 32'h0000_001F, 32'hFFFF_FFFF);
    apply("srl31",    1'b0, 4'd8, 32'h8000_0001, 32'h0000_001F, 32'h0000_0001);

    // LUI and undefined encodings
    apply("lui_a0",   1'b0, 4'd10, 32'h0, 32'h1234_5000, 32'h1234_5000);
    apply("lui_aF",   1'b0, 4'd10, 32'hFFFF_FFFF, 32'h1234_5000, 32'h1234_5000);
    apply("undef11",  1'b0, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    apply("undef15",  1'b0, 4'd15, 32'hDEAD_BEEF, 32'h1234_5000, 32'h0);

    // Random vectors against the reference model
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom;
      apply("add_rnd", 1'b0, 4'd0, a, b, ref_alu(4'd0, a, b));
      apply("sub_rnd", 1'b0, 4'd1, a, b, ref_alu(4'd1, a, b));
    end
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom;
      if (i % 4 == 0) b = a;
      if (i % 4 == 1) b = {~a[31], a[30:0]};
      apply("slt_rnd",  1'b0, 4'd2, a, b, ref_alu(4'd2, a, b));
      apply("sltu_rnd", 1'b0, 4'd3, a, b, ref_alu(4'd3, a, b));
    end
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      apply("sll_rnd", 1'b0, 4'd7, a, b, ref_alu(4'd7, a, b));
      apply("srl_rnd", 1'b0, 4'd8, a, b, ref_alu(4'd8, a, b));
      apply("sra_rnd", 1'b0, 4'd9, a, b, ref_alu(4'd9, a, b));
    end
    stim_done = 1'b1;
  end

  // Drain the scoreboard within a bounded number of cycles, then summarise.
  initial begin
    wait (stim_done);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
